// File: rtl/disp_pkg.sv
// Shared types and seven-segment constants for the multi-channel display controller.
package disp_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } state_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;

  // Active-high segment pattern for a decimal digit (bit0=a .. bit6=g).
  function automatic logic [SEG_W-1:0] digit_to_seg(input logic [DIGIT_W-1:0] digit);
    logic [SEG_W-1:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/disp_ctrl_seg_encode.sv
// Digit to seven-segment encoder with blank/dash override and output polarity selection.
module seg_encode
  import disp_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  input  logic               dash,
  output logic [SEG_W-1:0]   seg_c
);

  logic [SEG_W-1:0] pattern;

  // Dash wins over blank so an overflowed channel is always visibly marked.
  always_comb begin
    pattern = digit_to_seg(digit);
    if (dash) begin
      pattern = SEG_DASH;
    end else if (blank) begin
      pattern = SEG_BLANK;
    end
    seg_c = (ACTIVE_LOW != 0) ? ~pattern : pattern;
  end

endmodule

// File: rtl/disp_ctrl.sv
// Shared sequential double-dabble converter driving DIGITS seven-segment digits per channel,
// with a start/busy/done handshake, per-channel overflow flags and optional leading-zero blanking.
module disp_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned IN_WIDTH   = 6,
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned BLANK_LZ   = 0,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*IN_WIDTH-1:0]    in,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_CH-1:0]             ovf,
  output logic [NUM_CH*DIGITS*SEG_W-1:0] hex
);

  localparam int unsigned IN_ALL_W = NUM_CH * IN_WIDTH;
  localparam int unsigned BCD_W    = DIGITS * DIGIT_W;
  localparam int unsigned CNT_W    = $clog2(IN_WIDTH + 1);
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CH_HEX_W = DIGITS * SEG_W;
  localparam int unsigned HEX_W    = NUM_CH * CH_HEX_W;
  localparam logic [HEX_W-1:0] HEX_RST = (ACTIVE_LOW != 0) ? {HEX_W{1'b1}} : {HEX_W{1'b0}};

  state_t              state;
  state_t              next_state;
  logic [IN_ALL_W-1:0] snap;
  logic [CH_W-1:0]     ch;
  logic [IN_WIDTH-1:0] sreg;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic                ovf_bit;
  logic [CNT_W-1:0]    cnt;
  logic                last_ch;
  logic [DIGITS-1:0]   blank_d;
  logic                zero_above;
  logic [CH_HEX_W-1:0] ch_seg_c;

  assign last_ch = (ch == CH_W'(NUM_CH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_LOAD;
      ST_LOAD:  next_state = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_W'(1)) next_state = ST_LATCH;
      ST_LATCH: next_state = last_ch ? ST_DONE : ST_LOAD;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd[d*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        bcd_adj[d*DIGIT_W +: DIGIT_W] = bcd[d*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero; the ones digit never blanks.
  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
      zero_above = zero_above && (bcd[d*DIGIT_W +: DIGIT_W] == 4'd0);
      blank_d[d] = (BLANK_LZ != 0) && (d != 0) && zero_above;
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
    seg_encode #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_seg (
      .digit(bcd[g*DIGIT_W +: DIGIT_W]),
      .blank(blank_d[g]),
      .dash (ovf_bit),
      .seg_c(ch_seg_c[g*SEG_W +: SEG_W])
    );
  end

  // Datapath and registered outputs; busy/done are derived from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap    <= '0;
      ch      <= '0;
      sreg    <= '0;
      bcd     <= '0;
      ovf_bit <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= '0;
      hex     <= HEX_RST;
    end else begin
      busy <= (next_state == ST_LOAD) || (next_state == ST_SHIFT) || (next_state == ST_LATCH);
      done <= (next_state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            snap <= in;
            ch   <= '0;
          end
        end
        ST_LOAD: begin
          sreg    <= snap[32'(ch)*IN_WIDTH +: IN_WIDTH];
          bcd     <= '0;
          ovf_bit <= 1'b0;
          cnt     <= CNT_W'(IN_WIDTH);
        end
        ST_SHIFT: begin
          bcd     <= {bcd_adj[BCD_W-2:0], sreg[IN_WIDTH-1]};
          sreg    <= sreg << 1;
          ovf_bit <= ovf_bit | bcd_adj[BCD_W-1];
          cnt     <= cnt - CNT_W'(1);
        end
        ST_LATCH: begin
          ovf[ch] <= ovf_bit;
          hex[32'(ch)*CH_HEX_W +: CH_HEX_W] <= ch_seg_c;
          if (!last_ch) begin
            ch <= ch + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/disp_ctrl.md
# disp_ctrl

Parametrised multi-channel display controller for the PicoComputer board top level. It replaces the fixed 2-digit combinational bcd/ssd pair with a sequential double-dabble converter. The converter is shared across NUM_CH binary channels (PC, SP, OUT, ...) of arbitrary width and drives DIGITS seven-segment digits per channel. It adds an on-demand conversion handshake, overflow indication and optional leading-zero blanking.

## Interface
- NUM_CH, 2, number of binary channels converted per request
- IN_WIDTH, 6, bits per channel (unsigned)
- DIGITS, 2, decimal digits displayed per channel
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 never blanked)
- ACTIVE_LOW, 1, 1 = segment outputs inverted (segment lit = 0)
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in  in  NUM_CH*IN_WIDTH  channel c at in[c*IN_WIDTH +: IN_WIDTH]
- start  in  1  conversion request, sampled only in IDLE
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when all channels updated
- ovf  out  NUM_CH  per channel: value ≥ 10^DIGITS, valid from its LATCH
- hex  out  NUM_CH*DIGITS*7  channel c digit d (d=0 ones) at hex[(c*DIGITS+d)*7 +: 7], bit0=a … bit6=g

## Operation
- States: IDLE, LOAD, SHIFT, LATCH, DONE.
- IDLE: start=1 → snapshot all of in into an internal register, ch←0, go LOAD. Input changes after the snapshot have no effect.
- LOAD (1 cycle): shift reg ← snapshot channel ch; bcd reg (DIGITS*4 bits) ← 0; sticky ovf bit ← 0; bit counter ← IN_WIDTH.
- SHIFT (IN_WIDTH cycles): for every digit ≥5 add 3, then shift {bcd, shift reg} left by 1. A 1 leaving the top digit sets the sticky ovf bit. Counter decrements; the state exits when the counter reaches 0.
- LATCH (1 cycle): write ovf[ch] and the segment patterns for channel ch. If ch==NUM_CH-1 go DONE, else ch++ and go LOAD.
- DONE (1 cycle): done=1, busy=0, go IDLE.
- Patterns (active-high, before ACTIVE_LOW inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F, blank=00, dash=40.
- If ovf is set, all digits of the channel show dash; blanking does not apply.
- BLANK_LZ=1: digits above the most significant nonzero digit show blank; digit 0 always shows a numeral.
- start while busy, or during DONE, is ignored (not queued). start held high causes back-to-back conversions, each beginning in the IDLE cycle after DONE.
- hex/ovf for channels not yet latched keep their previous values during a conversion.

## Timing
- Reset (async, any state): state IDLE, busy=0, done=0, ovf=0, hex all blank (all 1s if ACTIVE_LOW, else 0s), snapshot/bcd cleared.
- start sampled at edge k → busy=1 from k+1.
- Per channel: IN_WIDTH+2 cycles. Channel c hex updates at edge k+(c+1)*(IN_WIDTH+2).
- done=1 in the cycle after edge k+NUM_CH*(IN_WIDTH+2). For the defaults that is 17 cycles from the start edge to done high.
- busy falls in the same cycle done rises.
- All outputs are registered; there is no combinational path from in/start to any output.

## Structure
- Package disp_pkg: state enum, SEG_BLANK/SEG_DASH constants, digit-to-pattern table/function.
- Sub-module seg_encode: combinational 4-bit digit + blank/dash controls → 7-bit pattern with ACTIVE_LOW handling. It is instantiated DIGITS times on the latch path.
- bcd reg width is DIGITS*4. Counter width is $clog2(IN_WIDTH+1). ch width is $clog2(NUM_CH) (minimum 1).

## Test plan
- Defaults, in={6'd37,6'd5}, start pulse → done 17 cycles after the start edge. ch0 hex = ~3F,~6D ("05"), ch1 = ~4F,~07 ("37"), ovf=00.
- BLANK_LZ=1, ch0=0, ch1=63 → ch0 digit1 = 7F (blank), digit0 = ~3F. ch1 "63" (~7D, ~4F).
- IN_WIDTH=7, DIGITS=2, ch0=100, ch1=99 → ovf=01, ch0 both digits ~40 (dash), ch1 "99".
- Pulse start, pulse start again at cycle 3, and change in at cycle 4 → second start ignored, results reflect the original snapshot, exactly one done pulse.
- Hold start high for 40 cycles → done pulses at cycles 17 and 35 after the first start edge, busy low only in the DONE/IDLE cycles between.
- Assert rst 5 cycles after start, release, then pulse start → busy drops immediately, hex all blank, ovf=0. The new conversion completes normally in 17 cycles.
